// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns single-cycle ticks into level pulses of programmable length,
// separated by at least GAP low cycles, queuing or retriggering on overlapping ticks.
module pulse_stretcher #(
    parameter int W      = 8,
    parameter int GAP    = 1,
    parameter int PEND_W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic [W-1:0] len,
    input  logic         retrig,
    output logic         sig,
    output logic         busy,
    output logic         done,
    output logic         overflow
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW_GAP} state_t;
    state_t            r_state;
    logic [W-1:0]      r_cnt;
    logic [7:0]        r_gcnt;
    logic [PEND_W-1:0] r_pend;
    logic [W-1:0]      w_load;
    logic              w_queue;
    assign w_load  = (len == '0) ? '0 : len - 1'b1;
    assign w_queue = tick && ((r_state == HIGH && !retrig) || (r_state == LOW_GAP && r_gcnt != '0));
    assign busy    = r_state != IDLE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_gcnt   <= '0;
            r_pend   <= '0;
            sig      <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done     <= 1'b0;
            overflow <= 1'b0;
            // a saturated queue drops the tick and reports it
            if (w_queue) begin
                if (&r_pend) overflow <= 1'b1;
                else         r_pend   <= r_pend + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (tick) begin
                        sig     <= 1'b1;
                        r_cnt   <= w_load;
                        r_state <= HIGH;
                    end
                end
                HIGH: begin
                    if (tick && retrig) begin
                        r_cnt <= w_load;
                    end else if (r_cnt == '0) begin
                        sig     <= 1'b0;
                        done    <= 1'b1;
                        r_gcnt  <= 8'(GAP - 1);
                        r_state <= LOW_GAP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                LOW_GAP: begin
                    if (r_gcnt != '0) begin
                        r_gcnt <= r_gcnt - 1'b1;
                    end else if (tick || r_pend != '0) begin
                        sig     <= 1'b1;
                        r_cnt   <= w_load;
                        r_state <= HIGH;
                        if (!tick) r_pend <= r_pend - 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
